branch_predictor: RTL and testbench
===================================

# branch_predictor

Fetch-stage branch predictor and target buffer. Sits upstream of the EX-stage branch resolution logic. Each cycle it looks up the fetch PC and supplies the `prediction` bit and predicted target that travel down the pipe with the instruction. It is trained by the resolved outcome reported from EX, and keeps saturating branch and mispredict statistics.

## Interface
- DBITS, 32, address and data width
- IDX_BITS, 4, table index width (2^IDX_BITS entries; 16 by default)
- clk  in  1  pipeline clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- IF_PC  in  DBITS  PC of the instruction being fetched this cycle
- prediction  out  1  1 = predict taken; consumed by fetch and carried to EX
- pred_target  out  DBITS  predicted taken target; 0 when prediction = 0
- EX_branch  in  1  EX holds a conditional branch this cycle (EX opcode = BRANCH)
- EX_PC  in  DBITS  PC of that branch
- EX_condFlag  in  1  resolved direction; 1 = taken
- EX_PC_IMM  in  DBITS  resolved taken target
- EX_mispredict  in  1  inverse of the branch handler's correct flag; sampled only when EX_branch = 1
- branch_count  out  16  resolved branches seen, saturating
- mispredict_count  out  16  mispredicted branches seen, saturating

## Operation
- Index = PC[IDX_BITS+1:2]; tag = PC[DBITS-1:IDX_BITS+2]; PC[1:0] ignored.
- Entry fields: valid, tag, target (DBITS), 2-bit counter (SNT=00, WNT=01, WT=10, ST=11).
- Lookup (combinational from IF_PC):
  - hit = valid and tag match.
  - prediction = hit and counter[1].
  - pred_target = target when prediction = 1, else 0.
- Update when EX_branch = 1, in this order of cases:
  - Hit, taken: counter saturating-increments (11 stays 11); target <= EX_PC_IMM.
  - Hit, not taken: counter saturating-decrements (00 stays 00); target unchanged.
  - Miss, taken: allocate or overwrite: valid=1, tag, target=EX_PC_IMM, counter=WT.
  - Miss, not taken: no table write.
- Statistics when EX_branch = 1:
  - branch_count increments.
  - mispredict_count increments if EX_mispredict = 1.
  - Both saturate at 16'hFFFF.
- When EX_branch = 0: no table or counter change; EX_condFlag, EX_PC_IMM and EX_mispredict are ignored.

## Timing
- Lookup latency is 0 cycles: outputs are combinational from IF_PC and the current table state.
- An update takes effect at the rising edge. It is first visible to a lookup in the following cycle.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update entry. There is no bypass.
- Reset (rst_n = 0 at a rising edge):
  - Every entry becomes valid=0, tag=0, target=0, counter=WNT.
  - branch_count and mispredict_count become 0.
- While rst_n = 0, prediction = 0 and pred_target = 0, independent of table contents.
- An update presented in a cycle where rst_n = 0 is discarded; reset wins.
- Two different branches aliasing the same index: the last taken-miss allocation replaces the entry. Tag mismatch counts as a miss.
- Index wrap: PCs 2^(IDX_BITS+2) bytes apart share an entry and are separated only by tag.

## Structure
- Shared package holds:
  - counter encodings SNT/WNT/WT/ST;
  - the BRANCH opcode constant 4'b0010;
  - the statistics width (16).
- Sub-module `sat_counter2`: combinational 2-bit saturating next-state.
  - Inputs: cur, taken. Output: next.
  - Instantiated once, on the update path.
- The table is a register array, not block RAM, because lookup is asynchronous.

## Test plan
- Reset state: hold rst_n=0 for 2 cycles, release; IF_PC=0x0000_0040 -> prediction=0, pred_target=0, both counts=0.
- Taken-miss allocation: EX_branch=1, EX_PC=0x40, EX_condFlag=1, EX_PC_IMM=0x100 -> next cycle, IF_PC=0x40 gives prediction=1, pred_target=0x100; branch_count=1.
- Saturation and training: repeat branch 0x40 with taken ×3 (counter reaches ST), then not-taken ×1 -> prediction stays 1 (WT); second not-taken -> prediction=0 (WNT); further not-taken leaves counter at SNT.
- Aliasing and not-taken miss:
  - With 0x40 trained taken, resolve 0x80 (same index, different tag) not taken -> no write; IF_PC=0x40 still predicts taken to 0x100.
  - Then resolve 0x80 taken to 0x200 -> 0x40 now misses (prediction=0); 0x80 predicts 0x200.
- Same-cycle read/write: IF_PC=0x40 and an update of 0x40 in the same cycle -> that cycle shows the old prediction, the next cycle the new one.
- Statistics:
  - 70000 branches, half with EX_mispredict=1 -> branch_count=16'hFFFF, mispredict_count=35000.
  - Asserting rst_n=0 mid-sequence clears both counters and all entries at that edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor and its helpers.
package branch_predictor_pkg;

   // 2-bit direction counter encodings; bit 1 is the predicted direction.
   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } cnt_e;

   // EX-stage opcode that marks a conditional branch.
   localparam logic [3:0] OP_BRANCH = 4'b0010;

   // Width of the branch / mispredict statistics counters.
   localparam int unsigned STAT_BITS = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_BITS-1:0] stat_sat_inc(input logic [STAT_BITS-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next-state for a 2-bit saturating direction counter.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cur,
   input  logic       taken,
   output logic [1:0] next
);

   // Step toward taken/not-taken, holding at the ends of the range.
   always_comb begin
      next = cur;
      if (taken) begin
         if (cur != CNT_ST) next = cur + 2'd1;
      end else begin
         if (cur != CNT_SNT) next = cur - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch direction predictor and target buffer with statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int unsigned DBITS    = 32,
   parameter int unsigned IDX_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DBITS-1:0]     IF_PC,
   output logic                 prediction,
   output logic [DBITS-1:0]     pred_target,
   input  logic                 EX_branch,
   input  logic [DBITS-1:0]     EX_PC,
   input  logic                 EX_condFlag,
   input  logic [DBITS-1:0]     EX_PC_IMM,
   input  logic                 EX_mispredict,
   output logic [STAT_BITS-1:0] branch_count,
   output logic [STAT_BITS-1:0] mispredict_count
);

   localparam int unsigned ENTRIES  = 1 << IDX_BITS;
   localparam int unsigned TAG_BITS = DBITS - IDX_BITS - 2;

   // Register array so the lookup can be purely combinational.
   logic                r_valid  [ENTRIES];
   logic [TAG_BITS-1:0] r_tag    [ENTRIES];
   logic [DBITS-1:0]    r_target [ENTRIES];
   logic [1:0]          r_cnt    [ENTRIES];

   logic [STAT_BITS-1:0] r_branch_count;
   logic [STAT_BITS-1:0] r_mispredict_count;

   logic [IDX_BITS-1:0] w_if_idx;
   logic [TAG_BITS-1:0] w_if_tag;
   logic                w_if_hit;
   logic [IDX_BITS-1:0] w_ex_idx;
   logic [TAG_BITS-1:0] w_ex_tag;
   logic                w_ex_hit;
   logic [1:0]          w_cnt_next;
   logic                w_unused;

   assign w_if_idx = IF_PC[IDX_BITS+1:2];
   assign w_if_tag = IF_PC[DBITS-1:IDX_BITS+2];
   assign w_ex_idx = EX_PC[IDX_BITS+1:2];
   assign w_ex_tag = EX_PC[DBITS-1:IDX_BITS+2];

   // Byte offset within the word never affects indexing or tagging.
   assign w_unused = ^{IF_PC[1:0], EX_PC[1:0]};

   // Lookup reads the current table state; no bypass from the update path.
   assign w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
   assign prediction  = rst_n && w_if_hit && r_cnt[w_if_idx][1];
   assign pred_target = prediction ? r_target[w_if_idx] : '0;

   assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

   sat_counter2 u_sat_counter2 (
      .cur   (r_cnt[w_ex_idx]),
      .taken (EX_condFlag),
      .next  (w_cnt_next)
   );

   // Table training from the resolved EX branch; reset overrides any update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= CNT_WNT;
         end
      end else if (EX_branch) begin
         if (w_ex_hit) begin
            r_cnt[w_ex_idx] <= w_cnt_next;
            if (EX_condFlag) r_target[w_ex_idx] <= EX_PC_IMM;
         end else if (EX_condFlag) begin
            // Taken miss allocates, evicting whatever aliased into this slot.
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= EX_PC_IMM;
            r_cnt[w_ex_idx]    <= CNT_WT;
         end
      end
   end

   // Saturating branch and mispredict statistics.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else if (EX_branch) begin
         r_branch_count <= stat_sat_inc(r_branch_count);
         if (EX_mispredict) r_mispredict_count <= stat_sat_inc(r_mispredict_count);
      end
   end

   assign branch_count     = r_branch_count;
   assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: the driver queues expected lookup/statistics values, the
// monitor pops and compares them on the falling edge of each checked cycle.
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] IF_PC;
   logic        prediction;
   logic [31:0] pred_target;
   logic        EX_branch;
   logic [31:0] EX_PC;
   logic        EX_condFlag;
   logic [31:0] EX_PC_IMM;
   logic        EX_mispredict;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   branch_predictor #(
      .DBITS    (32),
      .IDX_BITS (4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .IF_PC            (IF_PC),
      .prediction       (prediction),
      .pred_target      (pred_target),
      .EX_branch        (EX_branch),
      .EX_PC            (EX_PC),
      .EX_condFlag      (EX_condFlag),
      .EX_PC_IMM        (EX_PC_IMM),
      .EX_mispredict    (EX_mispredict),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic        pred;
      logic [31:0] tgt;
      logic [15:0] bc;
      logic [15:0] mc;
   } exp_t;

   exp_t        exp_q[$];
   logic        chk_req;
   int          n_checks;
   int          n_fail;
   logic [15:0] exp_bc;
   logic [15:0] exp_mc;

   // Monitor: one comparison per flagged cycle, away from the rising edge.
   always @(negedge clk) begin
      if (chk_req) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: check requested with no expected entry");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (prediction !== e.pred || pred_target !== e.tgt ||
                branch_count !== e.bc || mispredict_count !== e.mc) begin
               n_fail++;
               $display("FAIL %s: got pred=%0b tgt=%h bc=%0d mc=%0d, want pred=%0b tgt=%h bc=%0d mc=%0d",
                        e.name, prediction, pred_target, branch_count, mispredict_count,
                        e.pred, e.tgt, e.bc, e.mc);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      chk_req = 1'b0;
   endtask

   // Queue an expectation for the current cycle's outputs.
   task automatic expect_now(input string name, input logic pred, input logic [31:0] tgt);
      exp_t e;
      e.name = name;
      e.pred = pred;
      e.tgt  = tgt;
      e.bc   = exp_bc;
      e.mc   = exp_mc;
      exp_q.push_back(e);
      chk_req = 1'b1;
   endtask

   task automatic count_branch(input logic misp);
      if (exp_bc != 16'hFFFF) exp_bc++;
      if (misp && exp_mc != 16'hFFFF) exp_mc++;
   endtask

   // Present one resolved branch for a single cycle.
   task automatic branch(input logic [31:0] pc, input logic taken, input logic [31:0] imm,
                         input logic misp);
      EX_branch     = 1'b1;
      EX_PC         = pc;
      EX_condFlag   = taken;
      EX_PC_IMM     = imm;
      EX_mispredict = misp;
      step();
      EX_branch = 1'b0;
      count_branch(misp);
   endtask

   task automatic look(input string name, input logic [31:0] pc, input logic pred,
                       input logic [31:0] tgt);
      IF_PC = pc;
      expect_now(name, pred, tgt);
      step();
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      exp_bc        = '0;
      exp_mc        = '0;
      chk_req       = 1'b0;
      rst_n         = 1'b0;
      IF_PC         = 32'h40;
      EX_branch     = 1'b0;
      EX_PC         = '0;
      EX_condFlag   = 1'b0;
      EX_PC_IMM     = '0;
      EX_mispredict = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      look("reset_state", 32'h40, 1'b0, 32'h0);

      branch(32'h40, 1'b1, 32'h100, 1'b1);
      look("taken_miss_alloc", 32'h40, 1'b1, 32'h100);

      for (int i = 0; i < 3; i++) branch(32'h40, 1'b1, 32'h100, 1'b0);
      look("trained_strong", 32'h40, 1'b1, 32'h100);
      branch(32'h40, 1'b0, 32'h0, 1'b0);
      look("st_to_wt", 32'h40, 1'b1, 32'h100);
      branch(32'h40, 1'b0, 32'h0, 1'b1);
      look("wt_to_wnt", 32'h40, 1'b0, 32'h0);
      branch(32'h40, 1'b0, 32'h0, 1'b0);
      branch(32'h40, 1'b0, 32'h0, 1'b0);
      // From SNT one taken only reaches WNT; still predicts not taken.
      branch(32'h40, 1'b1, 32'h100, 1'b0);
      look("snt_floor", 32'h40, 1'b0, 32'h0);
      branch(32'h40, 1'b1, 32'h100, 1'b0);
      look("wnt_to_wt", 32'h40, 1'b1, 32'h100);
      branch(32'h40, 1'b1, 32'h100, 1'b0);

      look("other_index_miss", 32'h44, 1'b0, 32'h0);

      branch(32'h80, 1'b0, 32'h200, 1'b0);
      look("alias_nt_keeps_40", 32'h40, 1'b1, 32'h100);
      look("alias_nt_80_miss", 32'h80, 1'b0, 32'h0);

      branch(32'h80, 1'b1, 32'h200, 1'b1);
      look("alias_evicts_40", 32'h40, 1'b0, 32'h0);
      look("alias_80_alloc", 32'h80, 1'b1, 32'h200);

      // Same-cycle lookup and update: old entry now, new entry next cycle.
      IF_PC         = 32'h80;
      EX_branch     = 1'b1;
      EX_PC         = 32'h80;
      EX_condFlag   = 1'b0;
      EX_PC_IMM     = 32'h0;
      EX_mispredict = 1'b1;
      expect_now("same_cycle_old", 1'b1, 32'h200);
      step();
      EX_branch = 1'b0;
      count_branch(1'b1);
      look("same_cycle_new", 32'h80, 1'b0, 32'h0);

      branch(32'h80, 1'b1, 32'h300, 1'b0);
      look("hit_taken_new_target", 32'h80, 1'b1, 32'h300);

      // Reset mid-sequence with a competing update; reset must win.
      rst_n         = 1'b0;
      IF_PC         = 32'h80;
      EX_branch     = 1'b1;
      EX_PC         = 32'h80;
      EX_condFlag   = 1'b1;
      EX_PC_IMM     = 32'h400;
      EX_mispredict = 1'b1;
      expect_now("pred_gated_in_reset", 1'b0, 32'h0);
      step();
      EX_branch = 1'b0;
      rst_n     = 1'b1;
      exp_bc    = '0;
      exp_mc    = '0;
      look("mid_reset_cleared_80", 32'h80, 1'b0, 32'h0);
      branch(32'h80, 1'b0, 32'h0, 1'b0);
      look("mid_reset_no_stale_hit", 32'h80, 1'b0, 32'h0);

      // Statistics saturation: reset, then 70000 branches, half mispredicted.
      rst_n = 1'b0;
      step();
      rst_n  = 1'b1;
      exp_bc = '0;
      exp_mc = '0;
      EX_branch   = 1'b1;
      EX_PC       = 32'h1000;
      EX_condFlag = 1'b0;
      EX_PC_IMM   = 32'h0;
      for (int i = 0; i < 70000; i++) begin
         EX_mispredict = i[0];
         step();
         count_branch(i[0]);
      end
      EX_branch = 1'b0;
      look("stats_saturated", 32'h1000, 1'b0, 32'h0);

      step();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
